// File: rtl/csa_resolve_seq_pkg.sv
// Shared types and sizing helpers for the compressor-tree final-stage resolver.
// RW is the resolved result width; NCH is the number of CHUNK-bit add cycles.
package csa_resolve_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_rw(input int width);
        return width + 2;
    endfunction

    function automatic int calc_nch(input int width, input int chunk);
        return (width + 2 + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_resolve_seq_if.sv
// Operand/result handshake bundle between the compressor tree, the resolver
// and the product output stage.
interface csa_resolve_seq_if
    import csa_resolve_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    localparam int RW = calc_rw(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    result;
    logic [CNT_W-1:0] txn_count;

    modport master (
        output in_valid, sum_vec, carry_vec, out_ready,
        input  in_ready, out_valid, result, txn_count
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, out_ready,
        output in_ready, out_valid, result, txn_count
    );

endinterface

// File: rtl/csa_chunk_add.sv
// Combinational W-bit adder slice with carry in/out, used once per ADD cycle.
module csa_chunk_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // full-width add of the two operand slices plus the rippled carry
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/csa_resolve_seq.sv
// Sequential resolver: result = sum_vec + 2*carry_vec, CHUNK bits per cycle,
// carry rippling between cycles, behind valid/ready handshakes.
module csa_resolve_seq
    import csa_resolve_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    csa_resolve_seq_if.slave bus
);

    localparam int RW    = calc_rw(WIDTH);
    localparam int NCH   = calc_nch(WIDTH, CHUNK);
    localparam int PW    = NCH * CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               cy_r;
    logic [PW-1:0]      a_r;
    logic [PW-1:0]      b_r;
    logic [RW-1:0]      result_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               accept_s;
    logic               handshake_s;
    logic               last_s;
    logic [CHUNK-1:0]   a_chunk_s;
    logic [CHUNK-1:0]   b_chunk_s;
    logic [CHUNK-1:0]   sum_s;
    logic               cout_s;
    logic [RW-1:0]      result_nxt_s;

    assign last_s = (idx_r == IDX_W'(NCH - 1));

    // Operands are zero-padded to NCH*CHUNK bits, so the partial top chunk
    // needs no special slicing; its padded sum bits are simply never stored.
    always_comb begin
        a_chunk_s = a_r[idx_r * CHUNK +: CHUNK];
        b_chunk_s = b_r[idx_r * CHUNK +: CHUNK];
    end

    csa_chunk_add #(.W(CHUNK)) u_chunk_add (
        .a    (a_chunk_s),
        .b    (b_chunk_s),
        .cin  (cy_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // merge the current chunk's sum into the held result, other bits untouched
    always_comb begin
        result_nxt_s = result_r;
        for (int bi = 0; bi < RW; bi++) begin
            if ((bi / CHUNK) == int'(idx_r)) begin
                result_nxt_s[bi] = sum_s[bi % CHUNK];
            end else begin
                result_nxt_s[bi] = result_r[bi];
            end
        end
    end

    // next-state and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    handshake_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // datapath, handshake flags and saturating transaction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            cy_r        <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            cnt_r       <= '0;
        end else if (accept_s) begin
            a_r        <= PW'(bus.sum_vec);
            b_r        <= PW'({bus.carry_vec, 1'b0});
            idx_r      <= '0;
            cy_r       <= 1'b0;
            in_ready_r <= 1'b0;
        end else if (state_r == ADD) begin
            result_r <= result_nxt_s;
            cy_r     <= cout_s;
            if (last_s) begin
                idx_r       <= '0;
                out_valid_r <= 1'b1;
            end else begin
                idx_r       <= idx_r + IDX_W'(1);
            end
        end else if (handshake_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.txn_count = cnt_r;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Self-checking bench for csa_resolve_seq (WIDTH=16, CHUNK=4, CNT_W=8).
module tb_csa_resolve_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    csa_resolve_seq_if #(.WIDTH(16), .CNT_W(8)) bus ();

    csa_resolve_seq #(.WIDTH(16), .CHUNK(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    function automatic logic [17:0] ref_result(input logic [15:0] s, input logic [15:0] c);
        int unsigned v;
        v = int'(s) + 2 * int'(c);
        return 18'(v);
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Drive one operand pair; returns cycles from accept edge to out_valid.
    task automatic do_txn(input logic [15:0] s, input logic [15:0] c,
                          output int lat, output logic [17:0] res, output bit tmo);
        tmo = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) break;
            @(negedge clk);
        end
        bus.sum_vec   = s;
        bus.carry_vec = c;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.out_valid !== 1'b1) tmo = 1'b1;
        res = bus.result;
        if (bus.out_ready === 1'b1) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.sum_vec   = '0;
        bus.carry_vec = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.result !== 18'h0) $display("FAIL reset_result: got %h expected 0", bus.result); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'h0) $display("FAIL reset_count: got %h expected 0", bus.txn_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        int lat; logic [17:0] res; bit tmo;
        bus.out_ready = 1'b1;
        do_txn(16'h0003, 16'h0001, lat, res, tmo);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++; if (tmo) $display("FAIL basic_timeout: got no out_valid, expected out_valid"); else n_pass++;
        n_checks++; if (lat != 5) $display("FAIL basic_latency: got %0d expected 5", lat); else n_pass++;
        n_checks++; if (res !== 18'h00005) $display("FAIL basic_result: got %h expected 00005", res); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL basic_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_ripple();
        int lat; logic [17:0] res; bit tmo;
        bus.out_ready = 1'b1;
        do_txn(16'hFFFF, 16'hFFFF, lat, res, tmo);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++; if (tmo || res !== 18'h2FFFD) $display("FAIL ripple_full: got %h (timeout %0b) expected 2fffd", res, tmo); else n_pass++;
        do_txn(16'h000F, 16'h0001, lat, res, tmo);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++; if (tmo || res !== 18'h00011) $display("FAIL ripple_chunk0: got %h (timeout %0b) expected 00011", res, tmo); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL ripple_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [17:0] res; bit tmo;
        bus.out_ready = 1'b0;
        do_txn(16'h0003, 16'h0001, lat, res, tmo);
        n_checks++; if (tmo || res !== 18'h00005) $display("FAIL bp_first: got %h (timeout %0b) expected 00005", res, tmo); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.sum_vec   = 16'($urandom);
            bus.carry_vec = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (bus.result !== 18'h00005) $display("FAIL bp_hold_result: cycle %0d got %h expected 00005", i, bus.result); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, bus.out_valid); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b expected 0", i, bus.in_ready); else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL bp_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_extra: got %b expected 0", bus.out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        int lat; logic [17:0] res; bit tmo;
        bus.out_ready = 1'b1;
        bus.sum_vec   = 16'hFFFF;
        bus.carry_vec = 16'hFFFF;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.result !== 18'h0) $display("FAIL arst_result: got %h expected 0", bus.result); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'h0) $display("FAIL arst_count: got %0d expected 0", bus.txn_count); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL arst_ready: got %b expected 1", bus.in_ready); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(16'h0003, 16'h0001, lat, res, tmo);
        exp_cnt = sat_inc(exp_cnt);
        n_checks++; if (tmo || lat != 5) $display("FAIL arst_after_latency: got %0d (timeout %0b) expected 5", lat, tmo); else n_pass++;
        n_checks++; if (res !== 18'h00005) $display("FAIL arst_after_result: got %h expected 00005", res); else n_pass++;
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL arst_after_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s0, c0, s1, c1;
        int acc_q[$];
        logic [17:0] res_q[$];
        pulse_reset();
        s0 = 16'($urandom); c0 = 16'($urandom);
        s1 = 16'($urandom); c1 = 16'($urandom);
        bus.out_ready = 1'b1;
        bus.sum_vec   = s0;
        bus.carry_vec = c0;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_valid === 1'b1) res_q.push_back(bus.result);
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_q.push_back(cyc);
            @(posedge clk);
            @(negedge clk);
            if (acc_q.size() == 1) begin
                bus.sum_vec   = s1;
                bus.carry_vec = c1;
            end else if (acc_q.size() >= 2) begin
                bus.in_valid = 1'b0;
            end
        end
        exp_cnt = 2;
        n_checks++; if (acc_q.size() != 2) $display("FAIL b2b_accepts: got %0d expected 2", acc_q.size()); else n_pass++;
        if (acc_q.size() >= 2) begin
            n_checks++; if (acc_q[1] - acc_q[0] != 7) $display("FAIL b2b_spacing: got %0d expected 7", acc_q[1] - acc_q[0]); else n_pass++;
        end
        n_checks++; if (res_q.size() != 2) $display("FAIL b2b_results: got %0d expected 2", res_q.size()); else n_pass++;
        if (res_q.size() >= 2) begin
            n_checks++; if (res_q[0] !== ref_result(s0, c0)) $display("FAIL b2b_res0: got %h expected %h", res_q[0], ref_result(s0, c0)); else n_pass++;
            n_checks++; if (res_q[1] !== ref_result(s1, c1)) $display("FAIL b2b_res1: got %h expected %h", res_q[1], ref_result(s1, c1)); else n_pass++;
        end
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL b2b_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic [17:0] res; bit tmo;
        logic [15:0] s, c;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            s = 16'($urandom);
            c = 16'($urandom);
            do_txn(s, c, lat, res, tmo);
            exp_cnt = sat_inc(exp_cnt);
            n_checks++; if (tmo || lat != 5 || res !== ref_result(s, c))
                $display("FAIL rand_txn: s=%h c=%h got %h lat %0d expected %h lat 5", s, c, res, lat, ref_result(s, c));
            else n_pass++;
        end
        n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL rand_count: got %0d expected %0d", bus.txn_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        int lat; logic [17:0] res; bit tmo;
        logic [15:0] s, c;
        pulse_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            s = 16'($urandom);
            c = 16'($urandom);
            do_txn(s, c, lat, res, tmo);
            exp_cnt = sat_inc(exp_cnt);
            if (tmo || res !== ref_result(s, c)) begin
                n_checks++;
                $display("FAIL sat_txn: i=%0d got %h expected %h", i, res, ref_result(s, c));
            end
            if (i == 253 || i == 254 || i == 259) begin
                n_checks++; if (bus.txn_count !== 8'(exp_cnt)) $display("FAIL sat_count: i=%0d got %0d expected %0d", i, bus.txn_count, exp_cnt); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
